mem_iface: RTL

// - Main-memory access stage between the CONTROL microsequencer (RD/WRMain strobes) and the datapath (address/data).
// - Runs each access as a multi-cycle handshake over an internal word-addressed synchronous RAM.
// - Returns a one-cycle ACK, which the microsequencer's address incrementer waits on before advancing.
// - Registers read data toward the datapath C-bus mux.

---
 rtl/mem_iface_pkg.sv | 23 ++
 rtl/mem_iface_ram.sv | 23 ++
 rtl/mem_iface.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mem_iface_pkg.sv
// Shared definitions for the main-memory access stage: FSM state and op
// encodings plus the wait-state range check.
package mem_iface_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_t;

    localparam int WAIT_STATES_MAX = 15;
    localparam int WAIT_CNT_W      = 4;

    function automatic bit wait_states_ok(input int w);
        return (w >= 0) && (w <= WAIT_STATES_MAX);
    endfunction

endpackage

// File: rtl/mem_iface_ram.sv
// Single-port word-addressed synchronous RAM, read-first, registered output.
// The array carries no reset so it maps onto block RAM.
module mem_iface_ram #(
    parameter int DW = 32,
    parameter int AW = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/mem_iface.sv
// Multi-cycle RD/WR handshake onto an internal RAM with a one-cycle ACK.
// Optional misalignment trap: define MEM_IFACE_MISALIGN_TRAP_EN.
module mem_iface
    import mem_iface_pkg::*;
#(
    parameter int DATAWIDTH_DATA = 32,
    parameter int MEM_ADDR_LOG2  = 10,
    parameter int WAIT_STATES    = 2
) (
    input  logic                      MEM_IFACE_CLOCK_50,
    input  logic                      MEM_IFACE_ResetInLow_In,
    input  logic                      MEM_IFACE_RD_In,
    input  logic                      MEM_IFACE_WR_In,
    input  logic [DATAWIDTH_DATA-1:0] MEM_IFACE_Address_InBus,
    input  logic [DATAWIDTH_DATA-1:0] MEM_IFACE_Data_InBus,
    output logic [DATAWIDTH_DATA-1:0] MEM_IFACE_Data_OutBus,
    output logic                      MEM_IFACE_ACK_Out,
    output logic                      MEM_IFACE_Busy_Out,
    output logic                      MEM_IFACE_Error_Out
);

    localparam int AW = MEM_ADDR_LOG2;
    localparam int DW = DATAWIDTH_DATA;
    localparam logic [WAIT_CNT_W-1:0] WAIT_CNT = WAIT_CNT_W'(WAIT_STATES);

    if (!wait_states_ok(WAIT_STATES)) begin : g_wait_range
        $error("WAIT_STATES must be within 0..15");
    end

    logic clk;
    logic rst_n;
    assign clk   = MEM_IFACE_CLOCK_50;
    assign rst_n = MEM_IFACE_ResetInLow_In;

    state_t                state_reg, state_next;
    logic [WAIT_CNT_W-1:0] cnt_reg, cnt_next;
    op_t                   op_reg, op_next;
    logic [AW-1:0]         idx_reg, idx_next;
    logic [DW-1:0]         wdata_reg, wdata_next;
    logic [DW-1:0]         data_reg, data_next;

    logic          req;
    logic          commit;
    logic          trap;
    logic [AW-1:0] in_idx;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic [DW-1:0] ram_dout;
    logic          unused_addr;

    assign req    = MEM_IFACE_RD_In | MEM_IFACE_WR_In;
    assign in_idx = MEM_IFACE_Address_InBus[AW+1:2];
    assign commit = (state_reg == ST_BUSY) && (cnt_reg == '0);
    // Upper address bits wrap away; the low byte-offset bits matter only to the trap.
    assign unused_addr = ^{MEM_IFACE_Address_InBus[DW-1:AW+2], MEM_IFACE_Address_InBus[1:0]};

    // In IDLE the RAM already looks up the incoming address, so even with
    // zero wait states the read word is ready by the commit edge.
    assign ram_addr = (state_reg == ST_IDLE) ? in_idx : idx_reg;
    assign ram_we   = commit && (op_reg == OP_WRITE) && !trap;

    mem_iface_ram #(
        .DW(DW),
        .AW(AW)
    ) u_ram (
        .clk (clk),
        .we  (ram_we),
        .addr(ram_addr),
        .din (wdata_reg),
        .dout(ram_dout)
    );

`ifdef MEM_IFACE_MISALIGN_TRAP_EN
    logic mis_reg;
    logic err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mis_reg <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            if ((state_reg == ST_IDLE) && req) begin
                mis_reg <= |MEM_IFACE_Address_InBus[1:0];
            end
            err_reg <= commit && mis_reg;
        end
    end

    assign trap                = mis_reg;
    assign MEM_IFACE_Error_Out = err_reg;
`else
    assign trap                = 1'b0;
    assign MEM_IFACE_Error_Out = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= '0;
            op_reg    <= OP_READ;
            idx_reg   <= '0;
            wdata_reg <= '0;
            data_reg  <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            op_reg    <= op_next;
            idx_reg   <= idx_next;
            wdata_reg <= wdata_next;
            data_reg  <= data_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        op_next    = op_reg;
        idx_next   = idx_reg;
        wdata_next = wdata_reg;
        data_next  = data_reg;
        case (state_reg)
            ST_IDLE: begin
                if (req) begin
                    idx_next   = in_idx;
                    wdata_next = MEM_IFACE_Data_InBus;
                    op_next    = MEM_IFACE_RD_In ? OP_READ : OP_WRITE;
                    cnt_next   = WAIT_CNT;
                    state_next = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (cnt_reg == '0) begin
                    state_next = ST_ACK;
                    if ((op_reg == OP_READ) && !trap) begin
                        data_next = ram_dout;
                    end
                end else begin
                    cnt_next = cnt_reg - 1'b1;
                end
            end
            // Requests are ignored here so a still-held strobe is not re-serviced.
            ST_ACK:  state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    assign MEM_IFACE_ACK_Out     = (state_reg == ST_ACK);
    assign MEM_IFACE_Busy_Out    = (state_reg != ST_IDLE);
    assign MEM_IFACE_Data_OutBus = data_reg;

endmodule
